// File: rtl/ov7670_reg_sequencer_if.sv
// Sequencer-to-ROM and sequencer-to-SCCB-sender signal bundle.
// The master side is the sequencer; the slave side is the ROM plus the SCCB sender.
interface ov7670_reg_sequencer_if;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        send;
  logic        taken;
  logic [7:0]  id;
  logic [7:0]  rega;
  logic [7:0]  value;

  modport master (
    output rom_addr, send, id, rega, value,
    input  rom_data, taken
  );

  modport slave (
    input  rom_addr, send, id, rega, value,
    output rom_data, taken
  );
endinterface

// File: rtl/ov7670_reg_sequencer.sv
// Walks a {reg, value} ROM table and hands each write to an SCCB sender via send/taken.
// Define SEQ_TIMEOUT_EN to add a sticky watchdog on the taken handshake.
module ov7670_reg_sequencer #(
  parameter logic [7:0]  CAM_ID         = 8'h42,
  parameter logic [19:0] DELAY_CYCLES   = 20'd1000000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  ov7670_reg_sequencer_if.master        bus,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StSend, StDelay, StDone} state_e;

  localparam logic [15:0] EndMarker   = 16'hFFFF;
  localparam logic [15:0] DelayMarker = 16'hF0F0;

  state_e      r_state, w_state_d;
  logic [7:0]  r_addr, w_addr_d;
  logic [7:0]  r_rega, w_rega_d;
  logic [7:0]  r_value, w_value_d;
  logic        r_send, w_send_d;
  logic [19:0] r_dly, w_dly_d;
  logic        w_adv;

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] r_to, w_to_d;
  logic        r_error, w_error_d;
`else
  logic        w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_rega_d  = r_rega;
    w_value_d = r_value;
    w_send_d  = r_send;
    w_dly_d   = r_dly;
    w_adv     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    w_to_d    = r_to;
    w_error_d = r_error;
`endif
    case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_addr_d  = 8'd0;
          w_state_d = StFetch;
`ifdef SEQ_TIMEOUT_EN
          w_error_d = 1'b0;
`endif
        end
      end
      StFetch: w_state_d = StDecode;
      StDecode: begin
        if (bus.rom_data == EndMarker) begin
          w_state_d = StDone;
        end else if (bus.rom_data == DelayMarker) begin
          w_dly_d   = DELAY_CYCLES - 20'd1;
          w_state_d = StDelay;
        end else begin
          w_rega_d  = bus.rom_data[15:8];
          w_value_d = bus.rom_data[7:0];
          w_send_d  = 1'b1;
          w_state_d = StSend;
`ifdef SEQ_TIMEOUT_EN
          w_to_d    = 16'd0;
`endif
        end
      end
      StSend: begin
        if (bus.taken) begin
          w_send_d = 1'b0;
          w_adv    = 1'b1;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (r_to == TIMEOUT_CYCLES - 16'd1) begin
          w_send_d  = 1'b0;
          w_error_d = 1'b1;
          w_state_d = StDone;
        end else begin
          w_to_d = r_to + 16'd1;
        end
`endif
      end
      StDelay: begin
        if (r_dly == 20'd0) w_adv = 1'b1;
        else                w_dly_d = r_dly - 20'd1;
      end
      default: w_state_d = StIdle;
    endcase

    // The last ROM slot ends the walk rather than wrapping back to 0.
    if (w_adv) begin
      if (r_addr == 8'hFF) begin
        w_state_d = StDone;
      end else begin
        w_addr_d  = r_addr + 8'd1;
        w_state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_addr  <= 8'd0;
      r_rega  <= 8'd0;
      r_value <= 8'd0;
      r_send  <= 1'b0;
      r_dly   <= 20'd0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_rega  <= w_rega_d;
      r_value <= w_value_d;
      r_send  <= w_send_d;
      r_dly   <= w_dly_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to    <= 16'd0;
      r_error <= 1'b0;
    end else begin
      r_to    <= w_to_d;
      r_error <= w_error_d;
    end
  end
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign bus.rom_addr = r_addr;
  assign bus.send     = r_send;
  assign bus.id       = CAM_ID;
  assign bus.rega     = r_rega;
  assign bus.value    = r_value;
  assign busy         = (r_state != StIdle) && (r_state != StDone);
  assign done         = (r_state == StDone);

endmodule

// File: tb/tb_ov7670_reg_sequencer.sv
// Self-checking bench: a table-walk model predicts every write and the cycle it appears.
// Exercises both builds of SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_ov7670_reg_sequencer;
  localparam int D  = 10;
  localparam int TO = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, error;

  ov7670_reg_sequencer_if bus();

  ov7670_reg_sequencer #(
    .CAM_ID         (8'h42),
    .DELAY_CYCLES   (20'd10),
    .TIMEOUT_CYCLES (16'd100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int         q_gap[$];
  logic [7:0] q_rega[$];
  logic [7:0] q_value[$];
  int         end_gap;
  int         end_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rand_write();
    logic [15:0] w;
    w = 16'($urandom);
    while (w == 16'hFFFF || w == 16'hF0F0) w = 16'($urandom);
    return w;
  endfunction

  // Reference: every event (start or taken) is followed by FETCH+DECODE, and each delay
  // entry costs D cycles plus its own FETCH+DECODE; running off slot 255 skips the refetch.
  task automatic model_walk();
    int k;
    q_gap.delete(); q_rega.delete(); q_value.delete();
    k = 0;
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == 16'hFFFF) begin
        end_gap  = 3 + k * (D + 2);
        end_addr = a;
        return;
      end else if (rom[a] == 16'hF0F0) begin
        k++;
      end else begin
        q_gap.push_back(3 + k * (D + 2));
        q_rega.push_back(rom[a][15:8]);
        q_value.push_back(rom[a][7:0]);
        k = 0;
      end
    end
    end_gap  = 1 + k * (D + 2);
    end_addr = 255;
  endtask

  task automatic run_pass(input string name);
    int ref_c;
    int hold;
    model_walk();
    ref_c = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_start"}, busy, 1);
    for (int i = 0; i < q_gap.size(); i++) begin
      // taken and start are noise here: neither may be acted on outside SEND / IDLE / DONE.
      while (bus.send !== 1'b1 && cyc - ref_c < q_gap[i] + 4) begin
        bus.taken = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.taken = 1'b0;
      start     = 1'b0;
      chk({name, "_send_gap"}, cyc - ref_c, q_gap[i]);
      chk({name, "_rega"}, bus.rega, q_rega[i]);
      chk({name, "_value"}, bus.value, q_value[i]);
      hold = $urandom_range(0, 4);
      repeat (hold) @(negedge clk);
      chk({name, "_held_send"}, bus.send, 1);
      chk({name, "_held_value"}, {bus.rega, bus.value}, {q_rega[i], q_value[i]});
      bus.taken = 1'b1;
      ref_c = cyc;
      @(negedge clk);
      bus.taken = 1'b0;
      chk({name, "_send_drop"}, bus.send, 0);
    end
    while (done !== 1'b1 && cyc - ref_c < end_gap + 4) @(negedge clk);
    chk({name, "_done_gap"}, cyc - ref_c, end_gap);
    chk({name, "_busy_done"}, busy, 0);
    chk({name, "_end_addr"}, bus.rom_addr, end_addr);
    chk({name, "_error"}, error, 0);
  endtask

  initial begin
    int len;
    int s;
    bus.taken = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;

    repeat (3) @(negedge clk);
    chk("rst_send", bus.send, 0);
    chk("rst_regval", {bus.rega, bus.value}, 0);
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_flags", {busy, done, error}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_flags", {busy, done, bus.send}, 0);
    chk("id", bus.id, 8'h42);

    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    run_pass("single");
    // start sampled in DONE re-runs straight away
    run_pass("rerun");

    rom[0] = 16'h1280; rom[1] = 16'hF0F0; rom[2] = 16'h1104; rom[3] = 16'hFFFF;
    run_pass("delay");

    repeat (4) begin
      len = $urandom_range(0, 20);
      for (int a = 0; a < 256; a++) begin
        if (a < len)       rom[a] = ($urandom_range(0, 9) == 0) ? 16'hF0F0 : rand_write();
        else if (a == len) rom[a] = 16'hFFFF;
        else               rom[a] = 16'($urandom);
      end
      run_pass("rand");
    end

    for (int a = 0; a < 256; a++) rom[a] = rand_write();
    run_pass("full");

    rom[0] = 16'h3344; rom[1] = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    while (bus.send !== 1'b1 && cyc - s < 10) @(negedge clk);
    chk("mid_send_up", bus.send, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_send_async", {bus.send, busy, bus.rom_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_send_after", {bus.send, busy, done, bus.rom_addr}, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    while (bus.send !== 1'b1 && cyc - s < 10) @(negedge clk);
    s = cyc;
`ifdef SEQ_TIMEOUT_EN
    while (done !== 1'b1 && cyc - s < TO + 4) @(negedge clk);
    chk("wdog_cycle", cyc - s, TO);
    chk("wdog_flags", {error, done, bus.send}, 3'b110);
`else
    repeat (TO + 50) @(negedge clk);
    chk("nowdog_flags", {error, done, bus.send, busy}, 4'b0011);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
